// File: rtl/rom_reader_if.sv
// Bundle between rom_reader, the synchronous ROM it reads and the downstream consumer.
// master = the reader itself, slave = the surrounding command source, ROM and sink.
interface rom_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   len;
    logic                  busy;
    logic                  done;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] checksum;

    modport master (
        input  start, start_addr, len, rom_data, out_ready,
        output busy, done, rom_en, rom_addr, out_data, out_valid, checksum
    );

    modport slave (
        output start, start_addr, len, rom_data, out_ready,
        input  busy, done, rom_en, rom_addr, out_data, out_valid, checksum
    );
endinterface

// File: rtl/rom_reader.sv
// Reads len words from a 1-cycle-latency ROM and streams them out; optional running sum under ROM_READER_CHECKSUM_EN.
// Latency: first out_valid 3 cycles after start is sampled; 3 cycles per word with out_ready held high.
// Backpressure: word held in SEND until out_ready; the ROM is only read in READ, so stalls never re-read.
module rom_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic         clock,
    input  logic         reset,
    rom_reader_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_valid_q;
    logic                  done_q;
    logic                  accept;
    logic                  empty_cmd;
    logic                  xfer;
    logic                  last;

    assign accept    = (state == IDLE) && bus.start && (bus.len != '0);
    assign empty_cmd = (state == IDLE) && bus.start && (bus.len == '0);
    assign xfer      = (state == SEND) && bus.out_ready;
    assign last      = (remaining == CNT_ONE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = READ;
            READ: state_nxt = CAPT;
            CAPT: state_nxt = SEND;
            SEND: if (xfer) state_nxt = last ? IDLE : READ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur_addr    <= '0;
            remaining   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= empty_cmd || (xfer && last);
            if (accept) begin
                cur_addr  <= bus.start_addr;
                remaining <= bus.len;
            end
            // ROM data is valid in CAPT, one cycle after rom_en in READ
            if (state == CAPT) begin
                out_data_q  <= bus.rom_data;
                out_valid_q <= 1'b1;
            end
            if (xfer) begin
                remaining   <= remaining - CNT_ONE;
                cur_addr    <= cur_addr + ADDR_ONE;
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef ROM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q;

    always_ff @(posedge clock) begin
        if (reset || accept) checksum_q <= '0;
        else if (xfer)       checksum_q <= checksum_q + out_data_q;
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.rom_en    = (state == READ);
    assign bus.rom_addr  = cur_addr;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rom_reader.sv
// Directed and random commands against a word-stream model: expected words are rom[(start_addr+i) mod 8].
module tb_rom_reader;
    logic clock;
    logic reset;
    int   errors;
    int   checks;
    logic [7:0] rom [8];

    rom_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

    rom_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM with one cycle of read latency
    always @(posedge clock) begin
        if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},     bus.busy,      0);
        check({tag, "_done"},     bus.done,      0);
        check({tag, "_rom_en"},   bus.rom_en,    0);
        check({tag, "_rom_addr"}, bus.rom_addr,  0);
        check({tag, "_out_data"}, bus.out_data,  0);
        check({tag, "_out_vld"},  bus.out_valid, 0);
        check({tag, "_checksum"}, bus.checksum,  0);
    endtask

    function automatic logic [7:0] exp_checksum(input logic [7:0] sum);
`ifdef ROM_READER_CHECKSUM_EN
        return sum;
`else
        return 8'd0;
`endif
    endfunction

    // mode 0: out_ready always 1; mode 1: random; mode 2: stall first word 5 cycles
    task automatic run_cmd(input int sa, input int ln, input int mode, input bit ghost);
        int  words;
        int  reads;
        int  stall;
        int  lat;
        bit  exp_done;
        bit  fin;
        logic [7:0] sum;
        words = 0; reads = 0; stall = 0; lat = -1; sum = 8'd0;
        exp_done = (ln == 0);
        fin = 1'b0;
        @(negedge clock);
        bus.start      = 1'b1;
        bus.start_addr = 3'(sa);
        bus.len        = 4'(ln);
        bus.out_ready  = 1'b1;
        for (int k = 1; k <= 400 && !fin; k++) begin
            @(negedge clock);
            bus.start = ghost && (k == 4);
            if (bus.start) begin
                bus.start_addr = 3'($urandom);
                bus.len        = 4'd1;
            end
            check("done", bus.done, exp_done);
            check("busy", bus.busy, (ln != 0) && !exp_done);
            if (exp_done) begin
                check("rom_en_at_done", bus.rom_en, 0);
                fin = 1'b1;
            end else begin
                if (k == 1) check("checksum_clr", bus.checksum, 0);
                if (bus.rom_en) begin
                    check("rom_addr", bus.rom_addr, (sa + reads) % 8);
                    reads++;
                end
                if (bus.out_valid) begin
                    if (lat < 0) lat = k;
                    check("out_data", bus.out_data, rom[(sa + words) % 8]);
                end
                case (mode)
                    0: bus.out_ready = 1'b1;
                    1: bus.out_ready = 1'($urandom_range(0, 1));
                    default: begin
                        if (bus.out_valid && stall < 5) begin
                            bus.out_ready = 1'b0;
                            stall++;
                            check("stall_rom_en", bus.rom_en, 0);
                        end else begin
                            bus.out_ready = 1'b1;
                        end
                    end
                endcase
                if (bus.out_valid && bus.out_ready) begin
                    sum = sum + bus.out_data;
                    words++;
                    if (words == ln) exp_done = 1'b1;
                end
            end
        end
        bus.start = 1'b0;
        check("terminated", fin, 1);
        check("words", words, ln);
        check("reads", reads, ln);
        if (mode == 0 && ln != 0) check("latency", lat, 3);
        if (mode == 2) check("stall_cycles", stall, 5);
        @(negedge clock);
        check("done_single", bus.done, 0);
        check("checksum", bus.checksum, exp_checksum(sum));
    endtask

    initial begin
        int n;
        errors = 0;
        checks = 0;
        for (int i = 0; i < 8; i++) rom[i] = 8'(i + 1);
        bus.start = 1'b0; bus.start_addr = '0; bus.len = '0; bus.out_ready = 1'b0;
        bus.rom_data = '0;

        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_idle_outputs("reset");
        reset = 1'b0;

        run_cmd(0, 8, 0, 1'b0);   // full scan, checksum 0x24 when enabled
        run_cmd(6, 4, 0, 1'b0);   // wrap, checksum 0x12 when enabled
        run_cmd(2, 2, 2, 1'b0);   // backpressure
        run_cmd(3, 0, 0, 1'b0);   // empty command
        run_cmd(1, 5, 0, 1'b1);   // start while busy is ignored

        // reset in CAPT of the third word
        @(negedge clock);
        bus.start = 1'b1; bus.start_addr = 3'd0; bus.len = 4'd8; bus.out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 50 && n < 3; k++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.rom_en) n++;
        end
        check("third_read_seen", n, 3);
        @(negedge clock);
        check("capt_rom_en", bus.rom_en, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("midreset");
        @(negedge clock);
        check("midreset_no_done", bus.done, 0);
        run_cmd(5, 1, 0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            int sa;
            int ln;
            for (int i = 0; i < 8; i++) rom[i] = 8'($urandom);
            sa = $urandom_range(0, 7);
            ln = $urandom_range(0, 8);
            run_cmd(sa, ln, 1, (ln >= 2) && ($urandom_range(0, 1) == 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
Initiator/reader side of the synchronous ROM interface. It drives `rom_en` and `rom_addr` into a ROM with 1-cycle registered read latency, captures the returned word, and streams it out over a `valid`/`ready` handshake. On a `start` command it reads `len` consecutive words beginning at `start_addr`; addresses wrap modulo 2^ADDR_WIDTH. It sits between the ROM and any downstream consumer, e.g. a display or UART stage.

Parameters:
DATA_WIDTH, 8, width of ROM words and of `out_data`/`checksum`
ADDR_WIDTH, 3, ROM address width (ROM depth = 2^ADDR_WIDTH)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  command strobe; sampled only in IDLE
start_addr  input  ADDR_WIDTH  first address to read; sampled with `start`
len  input  ADDR_WIDTH+1  number of words to read (0..2^ADDR_WIDTH); sampled with `start`
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when a command completes
rom_en  output  1  ROM read enable
rom_addr  output  ADDR_WIDTH  ROM address
rom_data  input  DATA_WIDTH  ROM read data; valid the cycle after `rom_en`
out_data  output  DATA_WIDTH  streamed word
out_valid  output  1  `out_data` valid
out_ready  input  1  consumer accepts the word when `out_valid` and `out_ready` are both high
checksum  output  DATA_WIDTH  running sum (see Optional Feature)

Behaviour:
- Clocking and reset: single clock; `reset` is synchronous and active-high, applied at the rising edge.
- Reset values: state=IDLE; `busy`, `done`, `rom_en`, `out_valid` = 0; `rom_addr`, `out_data`, `checksum` = 0; internal address and remaining-count registers = 0.
- All outputs are registered or decoded directly from registered state. There is no combinational path from inputs to outputs.
- IDLE:
  - `start`=1 and `len`≠0: latch `cur_addr`=`start_addr` and `remaining`=`len`, clear `checksum`, go to READ.
  - `start`=1 and `len`=0: stay in IDLE and pulse `done` on the next cycle. No ROM access occurs.
- READ (1 cycle): `rom_en`=1, `rom_addr`=`cur_addr`. Then go to CAPT.
- CAPT (1 cycle): `rom_en`=0. At the end of this cycle, `out_data` <= `rom_data` and `out_valid` <= 1. Then go to SEND.
- SEND:
  - Hold `out_data` stable and `out_valid`=1 until `out_ready`=1.
  - On the handshake: `remaining` <= `remaining`-1; `cur_addr` <= `cur_addr`+1 mod 2^ADDR_WIDTH; `out_valid` <= 0.
  - If `remaining` was 1: go to IDLE and set `done`=1 for exactly one cycle. Otherwise go to READ.
- Latency: first `out_valid` is high 3 cycles after the `start` edge. With `out_ready` tied high, throughput is 1 word per 3 cycles.
- `start` while `busy`=1 is ignored; the latched command is unaffected.
- `rom_en` is never asserted outside READ, so backpressure never re-reads the ROM.
- `busy` falls in the same cycle `done` rises.
- `reset` during any state aborts the command. The next cycle shows reset values, with no `done` pulse.
- `len`=2^ADDR_WIDTH reads the whole ROM once; the final address is `start_addr`-1 mod depth.

Optional Feature:
Macro: `ROM_READER_CHECKSUM_EN`.
- Defined: on each SEND handshake, `checksum` <= `checksum` + `out_data`, truncated to DATA_WIDTH bits. `checksum` is cleared when a command is accepted and holds its value after `done` until the next accepted `start`.
- Undefined: `checksum` is tied to 0 and the adder is not built.

Test Plan:
1. Reset: assert `reset` 2 cycles → all outputs 0, `busy`=0, state IDLE.
2. Full scan: ROM holds 1..8 at addresses 0..7; `start_addr`=0, `len`=8, `out_ready`=1 → `rom_addr` sequence 0..7, `out_data` 1,2,…,8. First `out_valid` 3 cycles after `start`. `done` pulses once, 1 cycle after the 8th handshake. With `ROM_READER_CHECKSUM_EN`, `checksum`=0x24.
3. Wrap: `start_addr`=6, `len`=4 → addresses 6,7,0,1 and data 7,8,1,2. With the macro, `checksum`=0x12.
4. Backpressure: `start_addr`=2, `len`=2, hold `out_ready`=0 for 5 cycles in SEND → `out_data`=3 stable, `rom_en`=0 throughout. After release, the next word is 4 and `done` follows.
5. Edge commands: `len`=0 → `done` pulses 1 cycle after `start` and `rom_en` never asserts. `start` pulsed while `busy` → ignored; word count unchanged.
6. Reset mid-operation: assert `reset` in CAPT of the 3rd word → next cycle all outputs 0, no `done`. A new `start` with `start_addr`=5, `len`=1 then returns 6 and `done`.
